// File: rtl/paddle_engine.sv
// Pong paddle with tick-paced movement, hold-to-accelerate speed ramp, optional
// ball-tracking mode, hard clamping at the play-field limits and a registered pixel output.
module paddle_engine #(
  parameter int                 COLOR_W     = 3,
  parameter logic [COLOR_W-1:0] COLOR       = '1,
  parameter int                 PADDLE_W    = 5,
  parameter int                 PADDLE_H    = 55,
  parameter int                 START_X     = 5,
  parameter int                 START_Y     = 100,
  parameter int                 LIMIT_Y_MIN = 5,
  parameter int                 LIMIT_Y_MAX = 475,
  parameter int                 TICK_DIV    = 15,
  parameter int                 MAX_SPEED   = 4,
  parameter int                 ACCEL_STEPS = 8,
  parameter int                 AI_DEADBAND = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [9:0]         i_row,
  input  logic [9:0]         i_col,
  input  logic               i_control_up,
  input  logic               i_control_down,
  input  logic               i_mode,
  input  logic [9:0]         i_ball_y,
  input  logic [7:0]         i_ball_size_y,
  output logic [COLOR_W-1:0] o_rgb,
  output logic [9:0]         o_pos_x,
  output logic [9:0]         o_pos_y,
  output logic [7:0]         o_size_x,
  output logic [7:0]         o_size_y,
  output logic               o_moving
);

  localparam logic [15:0] LP_TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [10:0] LP_Y_MIN     = 11'(LIMIT_Y_MIN);
  localparam logic [10:0] LP_Y_MAX     = 11'(LIMIT_Y_MAX);
  localparam logic [10:0] LP_Y_BOT     = 11'(LIMIT_Y_MAX - PADDLE_H);
  localparam logic [10:0] LP_H         = 11'(PADDLE_H);
  localparam logic [10:0] LP_W         = 11'(PADDLE_W);
  localparam logic [10:0] LP_X         = 11'(START_X);
  localparam logic [10:0] LP_HALF_H    = 11'(PADDLE_H / 2);
  localparam logic [10:0] LP_DB        = 11'(AI_DEADBAND);
  localparam logic [3:0]  LP_MAX_SPD   = 4'(MAX_SPEED);
  localparam logic [7:0]  LP_HOLD_LAST = 8'(ACCEL_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  state_t               w_req;
  logic [3:0]           r_speed;
  logic [3:0]           w_speed_nxt;
  logic [7:0]           r_hold;
  logic [7:0]           w_hold_nxt;
  logic [9:0]           r_pos_y;
  logic [9:0]           w_pos_y_nxt;
  logic [15:0]          r_tick_cnt;
  logic [COLOR_W-1:0]   r_rgb;
  logic                 w_tick;
  logic [10:0]          w_pos11;
  logic [10:0]          w_step;
  logic [10:0]          w_pos_calc;
  logic [10:0]          w_bc;
  logic [10:0]          w_pc;
  logic                 w_hit;

  assign w_tick  = (r_tick_cnt == LP_TICK_LAST);
  assign w_pos11 = {1'b0, r_pos_y};
  assign w_bc    = {1'b0, i_ball_y} + 11'(i_ball_size_y >> 1);
  assign w_pc    = w_pos11 + LP_HALF_H;

  // Direction request: joystick buttons are active-low; auto mode steers centre to centre.
  always_comb begin
    w_req = IDLE;
    if (i_mode) begin
      if (w_bc + LP_DB < w_pc)      w_req = UP;
      else if (w_bc > w_pc + LP_DB) w_req = DOWN;
    end else begin
      if (!i_control_up && i_control_down)      w_req = UP;
      else if (i_control_up && !i_control_down) w_req = DOWN;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    w_hold_nxt  = r_hold;
    w_pos_calc  = w_pos11;
    w_step      = 11'd0;
    if (w_tick) begin
      if (w_req == IDLE) begin
        w_state_nxt = IDLE;
        w_speed_nxt = 4'd0;
        w_hold_nxt  = 8'd0;
      end else if (w_req != r_state) begin
        w_state_nxt = w_req;
        w_speed_nxt = 4'd1;
        w_hold_nxt  = 8'd0;
      end else if (r_hold == LP_HOLD_LAST) begin
        w_hold_nxt  = 8'd0;
        w_speed_nxt = (r_speed >= LP_MAX_SPD) ? LP_MAX_SPD : r_speed + 4'd1;
      end else begin
        w_hold_nxt  = r_hold + 8'd1;
      end

      // Move by the freshly computed speed; hitting a limit drops back to crawl speed.
      w_step = {7'd0, w_speed_nxt};
      if (w_state_nxt == UP) begin
        if (w_pos11 < LP_Y_MIN + w_step) begin
          w_pos_calc  = LP_Y_MIN;
          w_speed_nxt = 4'd1;
          w_hold_nxt  = 8'd0;
        end else begin
          w_pos_calc  = w_pos11 - w_step;
        end
      end else if (w_state_nxt == DOWN) begin
        if (w_pos11 + LP_H + w_step > LP_Y_MAX) begin
          w_pos_calc  = LP_Y_BOT;
          w_speed_nxt = 4'd1;
          w_hold_nxt  = 8'd0;
        end else begin
          w_pos_calc  = w_pos11 + w_step;
        end
      end
    end
    w_pos_y_nxt = w_pos_calc[9:0];
  end

  assign w_hit = ({1'b0, i_col} >= LP_X) && ({1'b0, i_col} < LP_X + LP_W) &&
                 ({1'b0, i_row} >= w_pos11) && ({1'b0, i_row} < w_pos11 + LP_H);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tick_cnt <= 16'd0;
      r_state    <= IDLE;
      r_speed    <= 4'd0;
      r_hold     <= 8'd0;
      r_pos_y    <= 10'(START_Y);
      r_rgb      <= '0;
    end else begin
      r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
      r_state    <= w_state_nxt;
      r_speed    <= w_speed_nxt;
      r_hold     <= w_hold_nxt;
      r_pos_y    <= w_pos_y_nxt;
      r_rgb      <= w_hit ? COLOR : '0;
    end
  end

  assign o_rgb    = r_rgb;
  assign o_pos_x  = 10'(START_X);
  assign o_pos_y  = r_pos_y;
  assign o_size_x = 8'(PADDLE_W);
  assign o_size_y = 8'(PADDLE_H);
  assign o_moving = (r_state != IDLE);

endmodule

// File: tb/tb_paddle_engine.sv
// Bench for paddle_engine: directed scenarios plus randomized inputs, all checked
// cycle by cycle against a behavioural model of paddle position, direction and speed.
module tb_paddle_engine;

  localparam int TD = 4, AS = 2, MS = 3;
  localparam int H = 55, W = 5, X0 = 5, Y0 = 100, YMIN = 5, YMAX = 475, DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] row = '0, col = '0;
  logic       up = 1'b1, down = 1'b1, mode = 1'b0;
  logic [9:0] ball_y = '0;
  logic [7:0] ball_sz = '0;
  logic [2:0] rgb;
  logic [9:0] pos_x, pos_y;
  logic [7:0] size_x, size_y;
  logic       moving;

  paddle_engine #(.TICK_DIV(TD), .ACCEL_STEPS(AS), .MAX_SPEED(MS)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_row(row), .i_col(col),
    .i_control_up(up), .i_control_down(down), .i_mode(mode),
    .i_ball_y(ball_y), .i_ball_size_y(ball_sz),
    .o_rgb(rgb), .o_pos_x(pos_x), .o_pos_y(pos_y),
    .o_size_x(size_x), .o_size_y(size_y), .o_moving(moving)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int m_pos, m_dir, m_spd, m_hold, m_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = Y0; m_dir = 0; m_spd = 0; m_hold = 0; m_n = 0;
  endtask

  function automatic int request();
    int bc, pc;
    if (mode) begin
      bc = int'(ball_y) + int'(ball_sz) / 2;
      pc = m_pos + H / 2;
      if (bc + DB < pc) return -1;
      if (bc > pc + DB) return 1;
      return 0;
    end
    if (!up && down) return -1;
    if (up && !down) return 1;
    return 0;
  endfunction

  task automatic model_tick();
    int r;
    r = request();
    if (r == 0) begin
      m_dir = 0; m_spd = 0; m_hold = 0;
    end else if (r != m_dir) begin
      m_dir = r; m_spd = 1; m_hold = 0;
    end else if (m_hold == AS - 1) begin
      m_hold = 0;
      m_spd = (m_spd + 1 > MS) ? MS : m_spd + 1;
    end else begin
      m_hold++;
    end
    if (m_dir < 0) begin
      if (m_pos < YMIN + m_spd) begin m_pos = YMIN; m_spd = 1; m_hold = 0; end
      else m_pos -= m_spd;
    end else if (m_dir > 0) begin
      if (m_pos + H + m_spd > YMAX) begin m_pos = YMAX - H; m_spd = 1; m_hold = 0; end
      else m_pos += m_spd;
    end
  endtask

  function automatic int exp_rgb();
    if (int'(col) >= X0 && int'(col) < X0 + W && int'(row) >= m_pos && int'(row) < m_pos + H)
      return 7;
    return 0;
  endfunction

  task automatic cyc();
    int er;
    er = exp_rgb();
    @(posedge clk);
    m_n++;
    if (m_n % TD == 0) model_tick();
    #1;
    check("pos_y", 32'(pos_y), 32'(m_pos));
    check("moving", 32'(moving), 32'(m_dir != 0));
    check("rgb", 32'(rgb), 32'(er));
  endtask

  task automatic to_tick();
    cyc();
    while (m_n % TD != 0) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[6];
    int prev;
    exp_seq = '{99, 98, 96, 94, 91, 88};

    // Reset values
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos_y", 32'(pos_y), 100);
    check("rst_rgb", 32'(rgb), 0);
    check("rst_moving", 32'(moving), 0);
    check("rst_pos_x", 32'(pos_x), 5);
    check("rst_size_x", 32'(size_x), 5);
    check("rst_size_y", 32'(size_y), 55);
    rst_n = 1'b1;
    model_reset();

    // Draw edges at pos_y = 100
    row = 10'd100; col = 10'd5;  cyc(); check("draw_100_5", 32'(rgb), 7);
    row = 10'd154; col = 10'd9;  cyc(); check("draw_154_9", 32'(rgb), 7);
    row = 10'd155; col = 10'd9;  cyc(); check("draw_155_9", 32'(rgb), 0);
    row = 10'd100; col = 10'd10; cyc(); check("draw_100_10", 32'(rgb), 0);
    row = 10'd99;  col = 10'd5;  cyc(); check("draw_99_5", 32'(rgb), 0);
    check("no_move_idle", 32'(pos_y), 100);

    // Manual acceleration upward
    up = 1'b0;
    for (int k = 0; k < 6; k++) begin
      to_tick();
      check("accel_seq", 32'(pos_y), 32'(exp_seq[k]));
    end

    // Run into top clamp
    for (int i = 0; i < 40 && pos_y != 10'd7; i++) to_tick();
    check("reach_7", 32'(pos_y), 7);
    to_tick();
    check("top_clamp", 32'(pos_y), 5);
    check("top_clamp_moving", 32'(moving), 1);

    // Both buttons pressed: idle and stationary
    down = 1'b0;
    for (int i = 0; i < 10; i++) begin
      to_tick();
      check("both_pos", 32'(pos_y), 5);
      check("both_moving", 32'(moving), 0);
    end

    // Down ramp then reversal
    up = 1'b1;
    repeat (8) to_tick();
    check("down_run", 32'(pos_y), 23);
    up = 1'b0; down = 1'b1;
    prev = int'(pos_y);
    to_tick();
    check("reversal_step", 32'(pos_y), 32'(prev - 1));

    // Asynchronous reset mid-operation
    cyc();
    rst_n = 1'b0;
    #1;
    check("async_pos_y", 32'(pos_y), 100);
    check("async_moving", 32'(moving), 0);
    check("async_rgb", 32'(rgb), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Auto tracking toward ball centre 304
    up = 1'b1; down = 1'b1; mode = 1'b1;
    ball_y = 10'd300; ball_sz = 8'd8;
    to_tick();
    check("auto_start", 32'(moving), 1);
    for (int i = 0; i < 100 && moving; i++) to_tick();
    check("auto_idle", 32'(moving), 0);
    prev = int'(pos_y) + H / 2;
    check("auto_band", 32'((prev >= 300) && (prev <= 308)), 1);
    repeat (5) to_tick();
    check("auto_hold", 32'(int'(pos_y) + H / 2), 32'(prev));

    // Bottom clamp in auto mode
    ball_y = 10'd1000; ball_sz = 8'd255;
    for (int i = 0; i < 100; i++) begin
      to_tick();
      if (pos_y > 10'd420) check("bottom_limit", 32'(pos_y), 420);
    end
    check("bottom_clamp", 32'(pos_y), 420);
    check("bottom_moving", 32'(moving), 1);

    // Randomized operation
    for (int i = 0; i < 400; i++) begin
      mode    = 1'($urandom_range(0, 3) == 0);
      up      = 1'($urandom_range(0, 1));
      down    = 1'($urandom_range(0, 1));
      ball_y  = 10'($urandom_range(0, 1023));
      ball_sz = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 12)) begin
        row = 10'($urandom_range(0, 511));
        col = 10'($urandom_range(0, 15));
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
